// File: rtl/tick_sram_logger_pkg.sv
// Shared definitions for the tick logger: FSM encodings, default SRAM widths and a saturating add helper.
package tick_sram_logger_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int SRAM_ADDR_W = 18;
  localparam int SRAM_DATA_W = 16;

  // Up to two samples can be lost in one cycle (pending plus a coincident tick at the final ack).
  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [1:0] b);
    logic [8:0] sum;
    sum = {1'b0, a} + {7'd0, b};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

endpackage

// File: rtl/tick_sram_logger_pend_slot.sv
// tick_pend_slot: one-entry valid+data holding register for a sample waiting behind an outstanding write.
// A load in the same cycle as a take refills the slot; drop empties it unconditionally.
module tick_pend_slot #(
  parameter int DATA_W = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              load,
  input  logic [DATA_W-1:0] load_dat,
  input  logic              take,
  input  logic              drop,
  output logic              vld,
  output logic [DATA_W-1:0] dat
);

  logic              vld_q, vld_d;
  logic [DATA_W-1:0] dat_q, dat_d;

  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    if (drop) begin
      vld_d = 1'b0;
    end else if (load) begin
      vld_d = 1'b1;
      dat_d = load_dat;
    end else if (take) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      vld_q <= 1'b0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  assign vld = vld_q;
  assign dat = dat_q;

endmodule

// File: rtl/tick_sram_logger.sv
// Logs a running tick count to sequential SRAM addresses over a req/ack write port, with a one-entry pending slot.
// Optional DROP_CNT output (saturating dropped-sample counter) is enabled by defining TICK_LOGGER_DROP_CNT_EN.
module tick_sram_logger
  import tick_sram_logger_pkg::*;
#(
  parameter int          ADDR_W     = SRAM_ADDR_W,
  parameter int          DATA_W     = SRAM_DATA_W,
  parameter int unsigned START_ADDR = 0,
  parameter int unsigned LAST_ADDR  = 1023
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              TICK,
  input  logic              EN,
  output logic              WR_REQ,
  output logic [ADDR_W-1:0] WR_ADDR,
  output logic [DATA_W-1:0] WR_DATA,
  input  logic              WR_ACK,
  output logic [DATA_W-1:0] COUNT,
  output logic              BUSY,
  output logic              DONE,
  output logic              OVERRUN
`ifdef TICK_LOGGER_DROP_CNT_EN
  , output logic [7:0]      DROP_CNT
`endif
);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] count_q, count_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              overrun_q, overrun_d;

  logic              accept, at_last;
  logic [DATA_W-1:0] sample;
  logic              pend_vld, pend_load, pend_take, pend_drop;
  logic [DATA_W-1:0] pend_dat;
  logic [1:0]        n_drop;

  assign accept  = TICK & EN & (state_q != ST_DONE);
  assign at_last = (addr_q == ADDR_W'(LAST_ADDR));
  assign sample  = count_q + DATA_W'(1);

  tick_pend_slot #(.DATA_W(DATA_W)) u_pend (
    .CLK      (CLK),
    .RST      (RST),
    .load     (pend_load),
    .load_dat (sample),
    .take     (pend_take),
    .drop     (pend_drop),
    .vld      (pend_vld),
    .dat      (pend_dat)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      addr_q    <= ADDR_W'(START_ADDR);
      data_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept) state_d = ST_REQ;
      ST_REQ: begin
        if (WR_ACK) begin
          if (at_last)                    state_d = ST_DONE;
          else if (!pend_vld && !accept)  state_d = ST_IDLE;
        end
      end
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath: the pending slot is refilled from a coincident tick so an ack never costs a sample.
  always_comb begin
    count_d   = accept ? sample : count_q;
    addr_d    = addr_q;
    data_d    = data_q;
    pend_load = 1'b0;
    pend_take = 1'b0;
    pend_drop = 1'b0;
    n_drop    = 2'd0;
    unique case (state_q)
      ST_IDLE: if (accept) data_d = sample;
      ST_REQ: begin
        if (WR_ACK) begin
          if (at_last) begin
            pend_drop = 1'b1;
            n_drop    = {1'b0, pend_vld} + {1'b0, accept};
          end else begin
            addr_d = addr_q + ADDR_W'(1);
            if (pend_vld) begin
              data_d    = pend_dat;
              pend_take = 1'b1;
              pend_load = accept;
            end else if (accept) begin
              data_d = sample;
            end
          end
        end else if (accept) begin
          if (pend_vld) n_drop    = 2'd1;
          else          pend_load = 1'b1;
        end
      end
      default: ;
    endcase
    overrun_d = overrun_q | (n_drop != 2'd0);
  end

  always_comb begin
    WR_REQ  = (state_q == ST_REQ);
    BUSY    = (state_q == ST_REQ);
    DONE    = (state_q == ST_DONE);
    WR_ADDR = addr_q;
    WR_DATA = data_q;
    COUNT   = count_q;
    OVERRUN = overrun_q;
  end

`ifdef TICK_LOGGER_DROP_CNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  always_comb drop_cnt_d = sat_add8(drop_cnt_q, n_drop);

  always_ff @(posedge CLK) begin
    if (RST) drop_cnt_q <= '0;
    else     drop_cnt_q <= drop_cnt_d;
  end

  assign DROP_CNT = drop_cnt_q;
`endif

endmodule

// File: tb/tb_tick_sram_logger.sv
// Bench for tick_sram_logger: directed scenarios with literal expectations plus a randomized run,
// all checked every cycle against a queue-based model of the logger.
module tb_tick_sram_logger;

  localparam int AW = 18;
  localparam int DW = 4;
  localparam int SA = 0;
  localparam int LA = 23;

  logic          CLK = 1'b0;
  logic          RST, TICK, EN, WR_ACK;
  logic          WR_REQ, BUSY, DONE, OVERRUN;
  logic [AW-1:0] WR_ADDR;
  logic [DW-1:0] WR_DATA, COUNT;
`ifdef TICK_LOGGER_DROP_CNT_EN
  logic [7:0]    DROP_CNT;
`endif

  always #5 CLK = ~CLK;

  tick_sram_logger #(
    .ADDR_W(AW), .DATA_W(DW), .START_ADDR(SA), .LAST_ADDR(LA)
  ) dut (
    .CLK(CLK), .RST(RST), .TICK(TICK), .EN(EN),
    .WR_REQ(WR_REQ), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA), .WR_ACK(WR_ACK),
    .COUNT(COUNT), .BUSY(BUSY), .DONE(DONE), .OVERRUN(OVERRUN)
`ifdef TICK_LOGGER_DROP_CNT_EN
    , .DROP_CNT(DROP_CNT)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model: queue of samples not yet acked (head = the write on the bus, at most one more behind it).
  int m_q[$];
  int m_addr  = SA;
  int m_count = 0;
  int m_drops = 0;
  bit m_done  = 1'b0;
  bit m_over  = 1'b0;
  int lost;
  bit acc;

  always @(posedge CLK) begin
    lost = 0;
    if (RST) begin
      m_q.delete();
      m_addr = SA; m_count = 0; m_drops = 0; m_done = 1'b0; m_over = 1'b0;
    end else if (!m_done) begin
      acc = TICK && EN;
      if (WR_ACK && m_q.size() > 0) begin
        void'(m_q.pop_front());
        if (m_addr == LA) begin
          m_done = 1'b1;
          lost   = m_q.size() + (acc ? 1 : 0);
          m_q.delete();
        end else begin
          m_addr++;
        end
      end
      if (acc) begin
        m_count = (m_count + 1) % (1 << DW);
        if (!m_done) begin
          if (m_q.size() < 2) m_q.push_back(m_count);
          else                lost++;
        end
      end
      if (lost > 0) m_over = 1'b1;
      m_drops = (m_drops + lost > 255) ? 255 : m_drops + lost;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_model();
    bit req;
    req = (m_q.size() > 0) && !m_done;
    chk("wr_req", 32'(WR_REQ), 32'(req));
    chk("busy", 32'(BUSY), 32'(req));
    chk("wr_addr", 32'(WR_ADDR), m_addr);
    if (req) chk("wr_data", 32'(WR_DATA), m_q[0]);
    chk("count", 32'(COUNT), m_count);
    chk("done", 32'(DONE), 32'(m_done));
    chk("overrun", 32'(OVERRUN), 32'(m_over));
`ifdef TICK_LOGGER_DROP_CNT_EN
    chk("drop_cnt", 32'(DROP_CNT), m_drops);
`endif
  endtask

  task automatic step(input bit t, input bit e, input bit a, input bit r);
    TICK = t; EN = e; WR_ACK = a; RST = r;
    @(posedge CLK);
    @(negedge CLK);
    check_model();
  endtask

  initial begin
    int thr;
    TICK = 0; EN = 0; WR_ACK = 0; RST = 1;

    // Reset state
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    chk("rst_req", 32'(WR_REQ), 0);
    chk("rst_addr", 32'(WR_ADDR), SA);
    chk("rst_data", 32'(WR_DATA), 0);
    chk("rst_count", 32'(COUNT), 0);

    // Single tick, ack three cycles after the request
    step(1, 1, 0, 0);
    chk("t1_req", 32'(WR_REQ), 1);
    chk("t1_addr", 32'(WR_ADDR), 0);
    chk("t1_data", 32'(WR_DATA), 1);
    chk("t1_count", 32'(COUNT), 1);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    step(0, 1, 1, 0);
    chk("t1_idle", 32'(WR_REQ), 0);
    chk("t1_busy", 32'(BUSY), 0);

    // Three ticks two cycles apart with the ack held off
    step(0, 0, 0, 1);
    step(1, 1, 0, 0);
    step(0, 1, 0, 0);
    step(1, 1, 0, 0);
    step(0, 1, 0, 0);
    step(1, 1, 0, 0);
    chk("t2_overrun", 32'(OVERRUN), 1);
    chk("t2_count", 32'(COUNT), 3);
    chk("t2_data0", 32'(WR_DATA), 1);
`ifdef TICK_LOGGER_DROP_CNT_EN
    chk("t2_dropcnt", 32'(DROP_CNT), 1);
`endif
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0);
    step(0, 1, 1, 0);
    chk("t2_req1", 32'(WR_REQ), 1);
    chk("t2_data1", 32'(WR_DATA), 2);
    chk("t2_addr1", 32'(WR_ADDR), 1);
    step(0, 1, 1, 0);
    chk("t2_idle", 32'(WR_REQ), 0);

    // Tick coincident with ack, pending empty
    step(0, 0, 0, 1);
    step(1, 1, 0, 0);
    step(0, 1, 0, 0);
    step(1, 1, 1, 0);
    chk("t3_req", 32'(WR_REQ), 1);
    chk("t3_data", 32'(WR_DATA), 2);
    chk("t3_addr", 32'(WR_ADDR), 1);
    chk("t3_overrun", 32'(OVERRUN), 0);

    // Continuous ticks with immediate ack: count wrap and run to the last address
    step(0, 0, 0, 1);
    step(1, 1, 0, 0);
    for (int k = 2; k <= 24; k++) begin
      step(1, 1, 1, 0);
      if (k == 16) begin
        chk("t5_wrap_data", 32'(WR_DATA), 0);
        chk("t5_wrap_addr", 32'(WR_ADDR), 15);
        chk("t5_wrap_count", 32'(COUNT), 0);
      end
      if (k == 17) chk("t5_count17", 32'(COUNT), 1);
    end
    step(0, 1, 1, 0);
    chk("t4_done", 32'(DONE), 1);
    chk("t4_req", 32'(WR_REQ), 0);
    chk("t4_count", 32'(COUNT), 8);
    chk("t4_overrun", 32'(OVERRUN), 0);
    for (int i = 0; i < 3; i++) step(1, 1, 1, 0);
    chk("t4_frozen", 32'(COUNT), 8);
    chk("t4_req_after", 32'(WR_REQ), 0);
    chk("t4_done_sticky", 32'(DONE), 1);

    // Reset while requesting with pending full
    step(0, 0, 0, 1);
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    chk("t6_pre_req", 32'(WR_REQ), 1);
    step(0, 1, 0, 1);
    chk("t6_req", 32'(WR_REQ), 0);
    chk("t6_count", 32'(COUNT), 0);
    chk("t6_addr", 32'(WR_ADDR), SA);
    chk("t6_data", 32'(WR_DATA), 0);
    step(1, 1, 0, 0);
    chk("t6_new_data", 32'(WR_DATA), 1);
    chk("t6_new_addr", 32'(WR_ADDR), SA);
    step(0, 1, 1, 0);
    chk("t6_pend_empty", 32'(WR_REQ), 0);

    // Randomized run, tick density varied per segment
    thr = 4;
    for (int i = 0; i < 3000; i++) begin
      bit r;
      r = (i % 150 == 0) || ($urandom_range(0, 299) == 0);
      if (i % 150 == 0) thr = $urandom_range(1, 9);
      step($urandom_range(0, 9) < thr, $urandom_range(0, 9) < 9,
           $urandom_range(0, 9) < 4, r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
